// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolution path: condition codes and the
// payloads carried by the two pipeline stages.
package branch_resolve_pkg;

  typedef logic [63:0] ulong_t;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_LT     = 3'd3,
    COND_GE     = 3'd4,
    COND_LE     = 3'd5,
    COND_GT     = 3'd6,
    COND_ALWAYS = 3'd7
  } cond_t;

  // Stage 1: raw operands as captured from the compare block
  typedef struct packed {
    cond_t  cond;
    logic   zero;
    logic   negitive;
    ulong_t pc;
    ulong_t target;
    logic   pred_taken;
  } s1_t;

  // Stage 2: resolved result handed back to fetch
  typedef struct packed {
    logic   taken;
    ulong_t next_pc;
    logic   mispredict;
  } s2_t;

endpackage

// File: rtl/branch_resolve_cond_eval.sv
// Pure combinational condition evaluator; also intended for a future
// conditional-move path. The zero&negitive combination is not filtered.
module BranchCondEval
  import branch_resolve_pkg::*;
(
  input  cond_t cond,
  input  logic  zero,
  input  logic  negitive,
  output logic  taken
);

  // Decode condition against compare flags
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NEVER:  taken = 1'b0;
      COND_EQ:     taken = zero;
      COND_NE:     taken = ~zero;
      COND_LT:     taken = negitive;
      COND_GE:     taken = ~negitive;
      COND_LE:     taken = negitive | zero;
      COND_GT:     taken = ~negitive & ~zero;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Two-stage valid/ready branch resolution: S1 captures the compare result,
// S2 holds taken/next_pc/mispredict. Keeps a running mispredict count.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int INSN_BYTES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  cond_t            in_cond,
  input  logic             in_zero,
  input  logic             in_negitive,
  input  ulong_t           in_pc,
  input  ulong_t           in_target,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output ulong_t           out_next_pc,
  output logic             out_mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  // vld_q[0] = S1 valid, vld_q[1] = S2 valid
  logic [1:0]       vld_q, vld_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_can_load;
  logic             s1_taken;

  BranchCondEval u_eval (
    .cond     (s1_q.cond),
    .zero     (s1_q.zero),
    .negitive (s1_q.negitive),
    .taken    (s1_taken)
  );

  // in_ready only depends on state and out_ready, never on in_valid
  assign s2_can_load = ~vld_q[1] | out_ready;
  assign in_ready    = ~vld_q[0] | s2_can_load;

  // Next-state: stage advance, flush kill, mispredict counting
  always_comb begin
    vld_d = vld_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    cnt_d = cnt_q;

    if (in_ready) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        s1_d.cond       = in_cond;
        s1_d.zero       = in_zero;
        s1_d.negitive   = in_negitive;
        s1_d.pc         = in_pc;
        s1_d.target     = in_target;
        s1_d.pred_taken = in_pred_taken;
      end
    end

    if (s2_can_load) begin
      vld_d[1] = vld_q[0];
      if (vld_q[0]) begin
        s2_d.taken      = s1_taken;
        s2_d.next_pc    = s1_taken ? s1_q.target : s1_q.pc + ulong_t'(INSN_BYTES);
        s2_d.mispredict = s1_taken ^ s1_q.pred_taken;
      end
    end

    // A handshake coinciding with flush still counts
    if (vld_q[1] && out_ready && s2_q.mispredict)
      cnt_d = cnt_q + CNT_W'(1);

    // Flush drops everything in flight, including a same-cycle input beat
    if (flush)
      vld_d = 2'b00;
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 2'b00;
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid      = vld_q[1];
  assign out_taken      = s2_q.taken;
  assign out_next_pc    = s2_q.next_pc;
  assign out_mispredict = s2_q.mispredict;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: the driver tags each beat with its
// hand-computed result, a negedge process queues it on acceptance and pops
// and compares whenever the DUT hands a result off.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready;
  cond_t       in_cond;
  logic        in_zero, in_negitive, in_pred_taken;
  ulong_t      in_pc, in_target;
  logic        out_valid, out_ready, out_taken, out_mispredict;
  ulong_t      out_next_pc;
  logic [31:0] mispredict_cnt;

  typedef struct {
    cond_t  c;
    logic   z;
    logic   n;
    ulong_t pc;
    ulong_t tgt;
    logic   pred;
    logic   et;
    ulong_t enpc;
    logic   em;
  } beat_t;

  typedef struct {
    logic   t;
    ulong_t npc;
    logic   m;
  } exp_t;

  exp_t drv_exp;
  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  branch_resolve #(.INSN_BYTES(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_zero(in_zero), .in_negitive(in_negitive),
    .in_pc(in_pc), .in_target(in_target), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_next_pc(out_next_pc),
    .out_mispredict(out_mispredict), .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor + scoreboard push; pop before push keeps same-edge order sane
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got next_pc 0x%0h with empty scoreboard", out_next_pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_taken", {63'd0, out_taken}, {63'd0, e.t});
          chk("out_next_pc", out_next_pc, e.npc);
          chk("out_mispredict", {63'd0, out_mispredict}, {63'd0, e.m});
        end
      end
      if (flush)
        sb_q.delete();
      else if (in_valid && in_ready)
        sb_q.push_back(drv_exp);
    end
  end

  task automatic set_beat(input beat_t b);
    in_cond       = b.c;
    in_zero       = b.z;
    in_negitive   = b.n;
    in_pc         = b.pc;
    in_target     = b.tgt;
    in_pred_taken = b.pred;
    drv_exp.t     = b.et;
    drv_exp.npc   = b.enpc;
    drv_exp.m     = b.em;
  endtask

  // One isolated beat with out_ready high; checks the 2-cycle latency
  task automatic single(input beat_t b);
    set_beat(b);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_after_n", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_after_n1", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
  endtask

  // Flags: 3v1 -> z0 n0, 2v2 -> z1 n0, 4v5 -> z0 n1; pc 0x1000, tgt 0x2000, pred 0
  beat_t vec [0:10] = '{
    '{COND_EQ,     1'b1, 1'b0, 64'h1000, 64'h2000, 1'b0, 1'b1, 64'h2000, 1'b1},
    '{COND_LT,     1'b0, 1'b0, 64'h1000, 64'h2000, 1'b0, 1'b0, 64'h1004, 1'b0},
    '{COND_GT,     1'b0, 1'b0, 64'h1000, 64'h2000, 1'b0, 1'b1, 64'h2000, 1'b1},
    '{COND_LE,     1'b1, 1'b0, 64'h1000, 64'h2000, 1'b0, 1'b1, 64'h2000, 1'b1},
    '{COND_NE,     1'b1, 1'b0, 64'h1000, 64'h2000, 1'b0, 1'b0, 64'h1004, 1'b0},
    '{COND_GE,     1'b0, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b0, 64'h1004, 1'b0},
    '{COND_LT,     1'b0, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b1, 64'h2000, 1'b1},
    '{COND_ALWAYS, 1'b0, 1'b0, 64'h1000, 64'h2000, 1'b1, 1'b1, 64'h2000, 1'b0},
    '{COND_GT,     1'b1, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b0, 64'h1004, 1'b0},
    '{COND_LE,     1'b1, 1'b1, 64'h1000, 64'h2000, 1'b1, 1'b1, 64'h2000, 1'b0},
    '{COND_NEVER,  1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h2000, 1'b0, 1'b0, 64'h0, 1'b0}
  };

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    beat_t b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_cond = COND_NEVER; in_zero = 1'b0; in_negitive = 1'b0;
    in_pc = '0; in_target = '0; in_pred_taken = 1'b0;
    drv_exp = '{1'b0, 64'd0, 1'b0};
    do_reset();

    // Reset state
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_taken", {63'd0, out_taken}, 64'd0);
    chk("rst_out_next_pc", out_next_pc, 64'd0);
    chk("rst_out_mispredict", {63'd0, out_mispredict}, 64'd0);
    chk("rst_cnt", {32'd0, mispredict_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Per-condition single beats, illegal flag pair, and pc wrap
    foreach (vec[i]) single(vec[i]);

    // Back-to-back COND_ALWAYS, pred 1,0,1,0,1 -> 2 mispredicts from zero
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b = '{COND_ALWAYS, 1'b0, 1'b0, 64'h100 * i, 64'h8000 + 64'h10 * i,
            (i % 2 == 0), 1'b1, 64'h8000 + 64'h10 * i, (i % 2 != 0)};
      set_beat(b);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      if (i >= 1) chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_out_valid_last", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    chk("b2b_drained", {63'd0, out_valid}, 64'd0);
    chk("b2b_cnt", {32'd0, mispredict_cnt}, 64'd2);

    // Backpressure: A (taken 0x3100), B (fall-through 0x4004), C (taken 0x5100)
    out_ready = 1'b0;
    set_beat('{COND_EQ, 1'b1, 1'b0, 64'h3000, 64'h3100, 1'b1, 1'b1, 64'h3100, 1'b0});
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_beat('{COND_NE, 1'b1, 1'b0, 64'h4000, 64'h4100, 1'b1, 1'b0, 64'h4004, 1'b1});
    @(posedge clk); #1;
    set_beat('{COND_LT, 1'b0, 1'b1, 64'h5000, 64'h5100, 1'b0, 1'b1, 64'h5100, 1'b1});
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_next_pc", out_next_pc, 64'h3100);
      chk("bp_hold_taken", {63'd0, out_taken}, 64'd1);
      if (k < 2) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", {63'd0, out_valid}, 64'd0);
    chk("bp_cnt", {32'd0, mispredict_cnt}, 64'd4);

    // Flush with both stages full and a third beat offered
    out_ready = 1'b0;
    set_beat('{COND_ALWAYS, 1'b0, 1'b0, 64'h6000, 64'h6100, 1'b0, 1'b1, 64'h6100, 1'b1});
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_beat('{COND_ALWAYS, 1'b0, 1'b0, 64'h7000, 64'h7100, 1'b0, 1'b1, 64'h7100, 1'b1});
    @(posedge clk); #1;
    set_beat('{COND_NEVER, 1'b0, 1'b0, 64'h7800, 64'h7900, 1'b1, 1'b0, 64'h7804, 1'b1});
    flush = 1'b1;
    chk("fl_full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("fl_nothing_later", {63'd0, out_valid}, 64'd0);
    end
    chk("fl_cnt", {32'd0, mispredict_cnt}, 64'd4);

    // Flush on an empty pipeline: in_ready reads 1 but the beat is dropped
    flush = 1'b1;
    in_valid = 1'b1;
    chk("fl_empty_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("fl_drop", {63'd0, out_valid}, 64'd0);
    end

    // Async reset mid-stream, asserted between edges
    for (int i = 0; i < 3; i++) begin
      b = '{COND_ALWAYS, 1'b0, 1'b0, 64'h9000, 64'h9100 + i, 1'b0, 1'b1, 64'h9100 + i, 1'b1};
      set_beat(b);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    chk("ar_pre_cnt", {32'd0, mispredict_cnt}, 64'd5);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_cnt", {32'd0, mispredict_cnt}, 64'd0);
    chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pipeline usable again after reset
    single(vec[0]);
    chk("post_rst_cnt", {32'd0, mispredict_cnt}, 64'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit sitting directly after the integer compare block in the execute stage. It consumes the compare flags (`zero`, `negitive` = a<b) together with a branch condition code and PC/target, and registers them through a two-stage valid/ready pipeline. It then emits the taken decision, the architectural next PC and a mispredict indication back to fetch, and keeps a running mispredict count.

## Interface
Parameters:
- `INSN_BYTES`, default 4: fall-through PC increment.
- `CNT_W`, default 32: mispredict counter width.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `flush`  in  1: synchronous pipeline kill.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: unit can accept a beat this cycle.
- `in_cond`  in  `cond_t` (3): condition code.
- `in_zero`  in  1: compare result a==b.
- `in_negitive`  in  1: compare result a<b.
- `in_pc`  in  `ulong_t` (64): branch PC.
- `in_target`  in  `ulong_t` (64): taken target.
- `in_pred_taken`  in  1: fetch's prediction.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `out_taken`  out  1: resolved direction.
- `out_next_pc`  out  `ulong_t` (64): resolved next PC.
- `out_mispredict`  out  1: `out_taken != pred_taken`.
- `mispredict_cnt`  out  `CNT_W`: count of mispredicts handed off.

## Operation
- Conditions (`cond_t`):
  - `COND_NEVER` = 0: not taken.
  - `COND_EQ`: zero.
  - `COND_NE`: !zero.
  - `COND_LT`: negitive.
  - `COND_GE`: !negitive.
  - `COND_LE`: negitive | zero.
  - `COND_GT`: !negitive & !zero.
  - `COND_ALWAYS` = 7: taken.
- Flag combination `zero=1, negitive=1` is illegal from the compare block. It is not checked, and the evaluation is still purely by the formulas above.
- Stage 1 (S1) captures cond, flags, pc, target and prediction on input handshake (`in_valid & in_ready`).
- Stage 2 (S2) holds the evaluated result.
  - `out_taken` = eval(cond, flags).
  - `out_next_pc` = taken ? target : pc + `INSN_BYTES`, computed mod 2^64 (wraps, no carry out).
  - `out_mispredict` = taken ^ pred_taken.
- Advance rules:
  - S2 loads from S1 when `!s2_valid | out_ready`.
  - `in_ready = !s1_valid | s2_can_load`.
  - The pipeline runs full throughput: one beat per cycle when `out_ready` is held high.
- Output data is held stable while `out_valid & !out_ready`.
- `mispredict_cnt` increments by 1 on each output handshake with `out_mispredict=1`. It wraps at 2^`CNT_W`.
- Flush:
  - Both valid bits clear on the next edge.
  - A beat offered during the same cycle is dropped, even though `in_ready` may read 1.
  - An output handshake in the same cycle as flush still counts a mispredict.
  - The counter is not cleared by flush.
- Reset values: `s1_valid`=0, `s2_valid`=0, `out_valid`=0, `out_taken`=0, `out_next_pc`=0, `out_mispredict`=0, `mispredict_cnt`=0; `in_ready`=1 from reset deassertion.
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.

## Timing
- Latency: a beat accepted at edge N appears with `out_valid=1` after edge N+1, provided S2 was free.
- Throughput: 1 beat/cycle.
- Backpressure: when `out_ready=0` the pipeline holds up to 2 beats. `in_ready` falls combinationally only when both stages are valid and `out_ready=0`.
- `in_ready` depends combinationally on `out_ready`. No path from `in_valid` to `in_ready`.
- Outputs `out_*` and `mispredict_cnt` are direct register outputs.

## Structure
- Add to `types` package:
  - `cond_t` 3-bit enum with the `COND_*` values above.
  - Existing `ulong_t` is reused.
- Sub-module `BranchCondEval`: combinational (cond, zero, negitive) → taken. It is reusable by a future conditional-move path.
- Pipeline registers and the counter live in `branch_resolve`.

## Test plan
- Single beat per condition, using the compare flags for 3 vs 1, 2 vs 2 and 4 vs 5, with pc=0x1000, target=0x2000. Required: EQ with 2,2 gives `next_pc`=0x2000; LT with 3,1 gives 0x1004; GT with 3,1 gives taken; LE with 2,2 gives taken; `out_valid` asserted 2 cycles after `in_valid`.
- Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, COND_NEVER → `next_pc`=0, `taken`=0.
- Mispredicts: 5 back-to-back beats with `out_ready`=1, alternating pred=1/0 on COND_ALWAYS → one result per cycle and `mispredict_cnt`=2.
- Backpressure: `out_ready`=0 for 4 cycles while 3 beats are offered → 2 beats accepted, `in_ready`=0, outputs stable. Releasing `out_ready` drains the beats in order.
- Flush: assert `flush` with both stages full and a beat offered → `out_valid`=0 next cycle, nothing emitted later, counter unchanged.
- Async reset: drop `rst_n` between edges mid-stream → `out_valid` and `mispredict_cnt` read 0 before the next edge.
